// File: rtl/parity_frame_checker_pkg.sv
// Shared types and helpers for the serial parity frame checker.
package pfc_pkg;

    // Frame checker states: waiting for frame_start, collecting data bits, awaiting parity bit.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2
    } pfc_state_e;

    // Bit-counter width able to hold 0..data_bits.
    function automatic int unsigned pfc_cnt_w(input int unsigned data_bits);
        return unsigned'($clog2(data_bits + 1));
    endfunction

endpackage

// File: rtl/parity_frame_checker_accum.sv
// One-bit running-parity accumulator with load (start of frame) and enable (fold in a bit).
module parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    input  logic bit_i,
    output logic fb_c
);

    logic acc_q;
    logic acc_d;

    // Feedback term acc ^ bit: next accumulator value and the final parity result.
    xorGate u_xor (
        .a_i (acc_q),
        .b_i (bit_i),
        .y_o (fb_c)
    );

    // Next accumulator value: load restarts from the current bit, enable folds it in.
    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = bit_i;
        end else if (en_i) begin
            acc_d = fb_c;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/xorGate.sv
// Two-input XOR stage used for parity feedback.
module xorGate (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);

    assign y_o = a_i ^ b_i;

endmodule

// File: rtl/parity_frame_checker.sv
// Deserialises LSB-first frames of DATA_BITS data bits plus a parity bit,
// checks parity and keeps a saturating count of failed frames.
module parity_frame_checker
    import pfc_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter bit          ODD_PARITY = 1'b0,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 frame_start,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_done,
    output logic                 parity_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    localparam int unsigned          CNT_W     = pfc_cnt_w(DATA_BITS);
    localparam logic [CNT_W-1:0]     LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

    pfc_state_e           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_out_q;
    logic                 frame_done_q;
    logic                 parity_err_q;
    logic [ERR_CNT_W-1:0] err_count_q;
    logic                 busy_q;

    logic acc_load_c;
    logic acc_en_c;
    logic acc_fb_c;
    logic fail_c;

    // Any frame_start restarts parity; data bits in DATA fold into it.
    assign acc_load_c = bit_valid & frame_start;
    assign acc_en_c   = bit_valid & ~frame_start & (state_q == S_DATA);
    assign fail_c     = acc_fb_c ^ ODD_PARITY;

    parity_accum u_accum (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (acc_load_c),
        .en_i   (acc_en_c),
        .bit_i  (bit_in),
        .fb_c   (acc_fb_c)
    );

    // Frame FSM with shift register, bit counter and registered result outputs.
    // Bits enter at the MSB and move down, so bit 0 lands at position 0 after DATA_BITS shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            frame_done_q <= 1'b0;
            parity_err_q <= 1'b0;
            err_count_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            parity_err_q <= 1'b0;
            if (bit_valid) begin
                if (frame_start) begin
                    // New frame, or abort of a partial one: this bit is bit 0.
                    state_q <= S_DATA;
                    cnt_q   <= CNT_W'(1);
                    shift_q <= {bit_in, shift_q[DATA_BITS-1:1]};
                    busy_q  <= 1'b1;
                end else begin
                    case (state_q)
                        S_DATA: begin
                            shift_q <= {bit_in, shift_q[DATA_BITS-1:1]};
                            cnt_q   <= cnt_q + CNT_W'(1);
                            if (cnt_q == LAST_DATA) begin
                                state_q <= S_PAR;
                            end
                        end
                        S_PAR: begin
                            data_out_q   <= shift_q;
                            frame_done_q <= 1'b1;
                            parity_err_q <= fail_c;
                            if (fail_c && (err_count_q != ERR_MAX)) begin
                                err_count_q <= err_count_q + ERR_CNT_W'(1);
                            end
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end
                        default: begin
                            // Idle bits without frame_start are ignored.
                        end
                    endcase
                end
            end
        end
    end

    assign data_out   = data_out_q;
    assign frame_done = frame_done_q;
    assign parity_err = parity_err_q;
    assign err_count  = err_count_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench: two checker instances (even parity with a 2-bit error
// counter, odd parity with an 8-bit one) share one serial input stream.
module tb_parity_frame_checker;

    localparam int unsigned DB = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;
    logic frame_start = 1'b0;

    logic [DB-1:0] e_data, o_data;
    logic          e_done, o_done, e_perr, o_perr, e_busy, o_busy;
    logic [1:0]    e_cnt;
    logic [7:0]    o_cnt;

    parity_frame_checker #(.DATA_BITS(DB), .ODD_PARITY(1'b0), .ERR_CNT_W(2)) u_even (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .data_out(e_data), .frame_done(e_done),
        .parity_err(e_perr), .err_count(e_cnt), .busy(e_busy)
    );

    parity_frame_checker #(.DATA_BITS(DB), .ODD_PARITY(1'b1), .ERR_CNT_W(8)) u_odd (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .data_out(o_data), .frame_done(o_done),
        .parity_err(o_perr), .err_count(o_cnt), .busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         cnt;
    } exp_t;

    exp_t q_e[$];
    exp_t q_o[$];
    int   checks = 0;
    int   errors = 0;
    int   done_e = 0;
    int   done_o = 0;

    // Reference model state: collected bits of the open frame and error tallies.
    bit   in_frame = 1'b0;
    bit   frame_bits[$];
    int   cnt_e = 0;
    int   cnt_o = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Frame rules applied to one accepted bit; completed frames go to the scoreboard.
    task automatic model_step(input bit b, input bit s);
        logic [7:0] w;
        int         ones;
        bit         fail_e, fail_o;
        exp_t       x;
        if (s) begin
            frame_bits.delete();
            frame_bits.push_back(b);
            in_frame = 1'b1;
        end else if (in_frame) begin
            if (frame_bits.size() < DB) begin
                frame_bits.push_back(b);
            end else begin
                w = '0;
                ones = int'(b);
                for (int i = 0; i < DB; i++) begin
                    w[i] = frame_bits[i];
                    ones += int'(frame_bits[i]);
                end
                fail_e = (ones % 2) != 0;
                fail_o = (ones % 2) != 1;
                if (fail_e && cnt_e < 3)   cnt_e++;
                if (fail_o && cnt_o < 255) cnt_o++;
                x.data = w; x.err = fail_e; x.cnt = cnt_e; q_e.push_back(x);
                x.data = w; x.err = fail_o; x.cnt = cnt_o; q_o.push_back(x);
                in_frame = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic s);
        bit_valid = v;
        bit_in = b;
        frame_start = s;
        if (v) model_step(b, s);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic chk_busy(input int exp);
        chk("even busy", int'(e_busy), exp);
        chk("odd busy", int'(o_busy), exp);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input int maxgap, input bit cb);
        for (int i = 0; i < DB; i++) begin
            repeat ($urandom_range(0, maxgap)) begin
                idle_cycle();
                if (cb && i > 0) chk_busy(1);
            end
            drive(1'b1, data[i], (i == 0));
            if (cb) chk_busy(1);
        end
        repeat ($urandom_range(0, maxgap)) begin
            idle_cycle();
            if (cb) chk_busy(1);
        end
        drive(1'b1, par, 1'b0);
        if (cb) chk_busy(0);
    endtask

    task automatic send_partial(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), (i == 0));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " even data_out"}, int'(e_data), 0);
        chk({tag, " even frame_done"}, int'(e_done), 0);
        chk({tag, " even parity_err"}, int'(e_perr), 0);
        chk({tag, " even err_count"}, int'(e_cnt), 0);
        chk({tag, " even busy"}, int'(e_busy), 0);
        chk({tag, " odd data_out"}, int'(o_data), 0);
        chk({tag, " odd frame_done"}, int'(o_done), 0);
        chk({tag, " odd parity_err"}, int'(o_perr), 0);
        chk({tag, " odd err_count"}, int'(o_cnt), 0);
        chk({tag, " odd busy"}, int'(o_busy), 0);
    endtask

    task automatic apply_reset();
        bit_valid = 1'b0;
        bit_in = 1'b0;
        frame_start = 1'b0;
        rst_n = 1'b0;
        in_frame = 1'b0;
        frame_bits.delete();
        cnt_e = 0;
        cnt_o = 0;
        #1;
        chk_zero("in reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Even-parity monitor: every frame_done must match the next expected frame.
    always @(negedge clk) begin : mon_even
        exp_t x;
        if (rst_n) begin
            if (e_done) begin
                done_e++;
                if (q_e.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL even unexpected frame_done: data_out=%0h", e_data);
                end else begin
                    x = q_e.pop_front();
                    chk("even data_out", int'(e_data), int'(x.data));
                    chk("even parity_err", int'(e_perr), int'(x.err));
                    chk("even err_count", int'(e_cnt), x.cnt);
                end
            end else if (e_perr) begin
                checks++; errors++;
                $display("FAIL even parity_err without frame_done: got 1 expected 0");
            end
        end
    end

    // Odd-parity monitor.
    always @(negedge clk) begin : mon_odd
        exp_t x;
        if (rst_n) begin
            if (o_done) begin
                done_o++;
                if (q_o.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL odd unexpected frame_done: data_out=%0h", o_data);
                end else begin
                    x = q_o.pop_front();
                    chk("odd data_out", int'(o_data), int'(x.data));
                    chk("odd parity_err", int'(o_perr), int'(x.err));
                    chk("odd err_count", int'(o_cnt), x.cnt);
                end
            end else if (o_perr) begin
                checks++; errors++;
                $display("FAIL odd parity_err without frame_done: got 1 expected 0");
            end
        end
    end

    initial begin
        int d0;
        int choice;
        repeat (2) @(posedge clk);
        #1;
        apply_reset();

        // Clean even frame, then the same data with the wrong parity bit.
        send_frame(8'hA5, 1'b0, 0, 1'b0);
        repeat (2) idle_cycle();
        send_frame(8'hA5, 1'b1, 0, 1'b0);
        repeat (2) idle_cycle();
        chk("err_count after bad frame", int'(e_cnt), 1);

        // Random gaps between bits; busy must stay high through the frame.
        send_frame(8'h3C, 1'b0, 5, 1'b1);
        repeat (2) idle_cycle();

        // Abort after 5 bits, then a full frame.
        d0 = done_e;
        send_partial(5);
        send_frame(8'hFF, 1'b0, 0, 1'b0);
        repeat (2) idle_cycle();
        chk("frame_done count after DATA abort", done_e - d0, 1);

        // Abort while waiting for parity: the start bit is never a parity bit.
        d0 = done_e;
        send_partial(8);
        send_frame(8'h5A, 1'b1, 1, 1'b0);
        repeat (2) idle_cycle();
        chk("frame_done count after PAR abort", done_e - d0, 1);

        // Saturation: five back-to-back failing frames on a 2-bit counter.
        apply_reset();
        d0 = done_e;
        for (int k = 0; k < 5; k++) send_frame(8'hA5, 1'b1, 0, 1'b0);
        repeat (2) idle_cycle();
        chk("back-to-back frame_done count", done_e - d0, 5);
        chk("saturated err_count", int'(e_cnt), 3);

        // Reset mid-frame, then a clean frame.
        send_partial(4);
        apply_reset();
        send_frame(8'h81, 1'b0, 0, 1'b0);
        repeat (2) idle_cycle();

        // Randomised traffic: full frames, aborts and ignored idle bits.
        for (int n = 0; n < 150; n++) begin
            choice = int'($urandom_range(0, 9));
            if (choice == 0) begin
                send_partial(int'($urandom_range(1, 8)));
            end else if (choice == 1) begin
                if (!in_frame) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                send_frame(8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
            end
        end
        repeat (4) idle_cycle();
        chk("even frames left unreported", q_e.size(), 0);
        chk("odd frames left unreported", q_o.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
